// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception unit at the M stage: holds SR, Cause, EPC and PRId,
// raises Req for interrupts/exceptions, and serves mfc0, mtc0 and eret.
module cp0_exc_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_2022,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0Add,
    input  logic [31:0] cp0In,
    input  logic [31:0] vpc,
    input  logic        delaySlotIn,
    input  logic [4:0]  excCodeIn,
    input  logic [5:0]  hwInt,
    input  logic        exlClr,
    output logic [31:0] cp0Out,
    output logic [31:0] epcOut,
    output logic        Req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_req = (|(hwInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (excCodeIn != 5'd0) & ~sr_exl;
    assign Req     = int_req | exc_req;

    assign sr_word    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
    assign cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
    assign epcOut     = epc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= hwInt;
            if (Req) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? 5'd0 : excCodeIn;
                cause_bd  <= delaySlotIn;
                epc       <= delaySlotIn ? vpc - 32'd4 : vpc;
            end else begin
                if (en && cp0Add == ADDR_SR) begin
                    sr_im  <= cp0In[15:10];
                    sr_exl <= cp0In[1];
                    sr_ie  <= cp0In[0];
                end
                if (en && cp0Add == ADDR_EPC)
                    epc <= cp0In;
                // eret wins over an mtc0 SR write landing on the same edge
                if (exlClr)
                    sr_exl <= 1'b0;
            end
        end
    end

    always_comb begin
        cp0Out = 32'd0;
        case (cp0Add)
            ADDR_SR:    cp0Out = sr_word;
            ADDR_CAUSE: cp0Out = cause_word;
            ADDR_EPC:   cp0Out = epc;
            ADDR_PRID:  cp0Out = PRID_VALUE;
            default:    cp0Out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Scoreboarded directed bench for cp0_exc_unit: stimulus pushes expected
// cp0Out/Req/epcOut, a negedge monitor pops and compares on each probe.
module tb_cp0_exc_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  cp0Add;
    logic [31:0] cp0In;
    logic [31:0] vpc;
    logic        delaySlotIn;
    logic [4:0]  excCodeIn;
    logic [5:0]  hwInt;
    logic        exlClr;
    logic [31:0] cp0Out;
    logic [31:0] epcOut;
    logic        Req;

    cp0_exc_unit dut (
        .clk(clk), .reset(reset), .en(en), .cp0Add(cp0Add), .cp0In(cp0In),
        .vpc(vpc), .delaySlotIn(delaySlotIn), .excCodeIn(excCodeIn),
        .hwInt(hwInt), .exlClr(exlClr), .cp0Out(cp0Out), .epcOut(epcOut),
        .Req(Req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] cp0;
        logic        req;
        logic [31:0] epc;
    } sb_item_t;

    sb_item_t sb[$];
    logic     probe;
    int       n_total;
    int       n_pass;

    always @(negedge clk) begin
        if (probe) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL scoreboard_empty: probe with no expected item");
            end else begin
                sb_item_t it;
                it = sb.pop_front();
                n_total++;
                if (cp0Out === it.cp0) n_pass++;
                else $display("FAIL %s.cp0Out: got %h want %h", it.name, cp0Out, it.cp0);
                n_total++;
                if (Req === it.req) n_pass++;
                else $display("FAIL %s.Req: got %b want %b", it.name, Req, it.req);
                n_total++;
                if (epcOut === it.epc) n_pass++;
                else $display("FAIL %s.epcOut: got %h want %h", it.name, epcOut, it.epc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read addr in the current cycle; monitor compares at the coming negedge.
    task automatic chk(input string name, input logic [4:0] addr,
                       input logic [31:0] exp_cp0, input logic exp_req,
                       input logic [31:0] exp_epc);
        sb_item_t it;
        it.name = name;
        it.cp0  = exp_cp0;
        it.req  = exp_req;
        it.epc  = exp_epc;
        cp0Add = addr;
        sb.push_back(it);
        probe = 1'b1;
        @(negedge clk);
        #1;
        probe = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_pass = 0;
        probe = 1'b0;
        reset = 1'b0;
        en = 1'b0; cp0Add = 5'd0; cp0In = 32'd0; vpc = 32'd0;
        delaySlotIn = 1'b0; excCodeIn = 5'd0; hwInt = 6'd0; exlClr = 1'b0;

        // reset then read back
        tick(); tick();
        reset = 1'b1;
        chk("rst_sr", 5'd12, 32'h0, 1'b0, 32'h0);
        tick(); chk("rst_cause", 5'd13, 32'h0, 1'b0, 32'h0);
        tick(); chk("rst_epc", 5'd14, 32'h0, 1'b0, 32'h0);
        tick(); chk("rst_prid", 5'd15, 32'h0000_2022, 1'b0, 32'h0);

        // masked interrupt
        tick(); en = 1'b1; cp0Add = 5'd12; cp0In = 32'h0000_0401;
        tick(); en = 1'b0;
        hwInt = 6'b000001; vpc = 32'h0000_3010;
        chk("int_req", 5'd12, 32'h0000_0401, 1'b1, 32'h0);
        tick(); chk("int_sr", 5'd12, 32'h0000_0403, 1'b0, 32'h0000_3010);
        tick(); chk("int_cause", 5'd13, 32'h0000_0400, 1'b0, 32'h0000_3010);
        tick(); chk("int_epc", 5'd14, 32'h0000_3010, 1'b0, 32'h0000_3010);

        // delay-slot exception
        tick(); hwInt = 6'd0; en = 1'b1; cp0Add = 5'd12; cp0In = 32'h0;
        tick(); en = 1'b0;
        excCodeIn = 5'd10; delaySlotIn = 1'b1; vpc = 32'h0000_3024;
        chk("exc_req", 5'd12, 32'h0, 1'b1, 32'h0000_3010);
        tick(); excCodeIn = 5'd0; delaySlotIn = 1'b0;
        chk("exc_cause", 5'd13, 32'h8000_0028, 1'b0, 32'h0000_3020);
        tick(); chk("exc_epc", 5'd14, 32'h0000_3020, 1'b0, 32'h0000_3020);
        tick(); exlClr = 1'b1;
        tick(); exlClr = 1'b0;
        excCodeIn = 5'd10; delaySlotIn = 1'b1; vpc = 32'h0;
        chk("exc_req_wrap", 5'd12, 32'h0, 1'b1, 32'h0000_3020);
        tick(); excCodeIn = 5'd0; delaySlotIn = 1'b0;
        chk("wrap_epc", 5'd14, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC);

        // interrupt beats exception and mtc0 EPC in the same cycle
        tick(); en = 1'b1; cp0Add = 5'd12; cp0In = 32'h0000_0401;
        tick(); en = 1'b0;
        hwInt = 6'b000001; excCodeIn = 5'd4; vpc = 32'h0000_3040;
        en = 1'b1; cp0In = 32'h1234_5678;
        chk("pri_req", 5'd14, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC);
        tick(); en = 1'b0; excCodeIn = 5'd0;
        chk("pri_epc", 5'd14, 32'h0000_3040, 1'b0, 32'h0000_3040);
        tick(); chk("pri_cause", 5'd13, 32'h0000_0400, 1'b0, 32'h0000_3040);

        // eret together with an SR write that tries to keep EXL set
        tick(); exlClr = 1'b1; en = 1'b1; cp0In = 32'h0000_FC03;
        chk("eret_pre", 5'd12, 32'h0000_0403, 1'b0, 32'h0000_3040);
        tick(); exlClr = 1'b0; en = 1'b0; vpc = 32'h0000_3050;
        chk("eret_sr", 5'd12, 32'h0000_FC01, 1'b1, 32'h0000_3040);
        tick(); chk("eret_cause", 5'd13, 32'h0000_0400, 1'b0, 32'h0000_3050);

        // write masking and read-only registers
        tick(); en = 1'b1; cp0Add = 5'd12; cp0In = 32'hFFFF_FFFF;
        tick(); en = 1'b0;
        chk("mask_sr", 5'd12, 32'h0000_FC03, 1'b0, 32'h0000_3050);
        tick(); en = 1'b1; hwInt = 6'b100001;
        chk("ro_cause_pre", 5'd13, 32'h0000_0400, 1'b0, 32'h0000_3050);
        tick(); en = 1'b0;
        chk("ro_cause", 5'd13, 32'h0000_8400, 1'b0, 32'h0000_3050);
        tick(); en = 1'b1; cp0Add = 5'd15;
        tick(); en = 1'b0;
        chk("ro_prid", 5'd15, 32'h0000_2022, 1'b0, 32'h0000_3050);
        tick(); chk("unmapped", 5'd20, 32'h0, 1'b0, 32'h0000_3050);

        // reset mid-handler: interrupt re-fires only after IE is set again
        tick(); reset = 1'b0;
        tick(); reset = 1'b1;
        chk("rst_mid", 5'd12, 32'h0, 1'b0, 32'h0);
        tick(); en = 1'b1; cp0Add = 5'd12; cp0In = 32'h0000_0401;
        tick(); en = 1'b0;
        chk("refire", 5'd12, 32'h0000_0401, 1'b1, 32'h0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: %0d items left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 block at the M stage; the consuming end of the exception fields carried down the pipeline registers (pc, delay-slot flag, exception code).
- Holds SR, Cause, EPC and PRId.
- Evaluates hardware interrupts and pipeline exceptions, and drives Req. Req flushes every pipeline register and redirects fetch to 0x0000_4180.
- Serves mfc0 reads, mtc0 writes, and eret (EXL clear / EPC return).

Parameters:
- PRID_VALUE, 32'h0000_2022, constant returned on reads of register 15.
- HANDLER_PC, 32'h0000_4180, exception entry address (informational; consumed by fetch logic).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- en  in  1  mtc0 write enable (M stage)
- cp0Add  in  5  register number for read and write
- cp0In  in  32  mtc0 write data
- vpc  in  32  pc of the instruction currently in M
- delaySlotIn  in  1  M instruction is in a branch delay slot
- excCodeIn  in  5  pipeline exception code for the M instruction (0 = none)
- hwInt  in  6  external interrupt lines, level-sensitive
- exlClr  in  1  eret in M
- cp0Out  out  32  read data (combinational)
- epcOut  out  32  current EPC register
- Req  out  1  take exception/interrupt this cycle (combinational)

Behaviour:
- Registers:
  - SR: IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause: BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC: full 32 bits.
- Reset (reset==0 at posedge): SR=0, Cause=0, EPC=0. Outputs follow: cp0Out = register-mapped value, epcOut=0, Req=0 (IE=0, EXL=0).
- Combinational request logic:
  - intReq = |(hwInt & SR.IM) & SR.IE & ~SR.EXL
  - excReq = (excCodeIn != 0) & ~SR.EXL
  - Req = intReq | excReq
  - Interrupt has priority over exception.
- Cause.IP is loaded from hwInt at every posedge (not in reset), regardless of any other event.
- Posedge, Req==1 (highest priority):
  - SR.EXL <= 1
  - Cause.ExcCode <= intReq ? 5'd0 : excCodeIn
  - Cause.BD <= delaySlotIn
  - EPC <= delaySlotIn ? vpc - 4 : vpc (32-bit modulo, wraps: vpc 0 with BD gives FFFF_FFFC)
  - The en write and exlClr in the same cycle are ignored.
- Posedge, Req==0, exlClr==1: SR.EXL <= 0. A simultaneous en write is still applied; if the write targets SR, the written EXL value is overridden by the clear.
- Posedge, Req==0, en==1:
  - cp0Add 12: SR <= cp0In masked to bits 15:10, 1, 0.
  - cp0Add 14: EPC <= cp0In.
  - cp0Add 13 and 15: Cause and PRId are read-only; write ignored.
  - Any other address: ignored.
- Reads (cp0Out): combinational on current register state.
  - 12 → SR, 13 → Cause, 14 → EPC, 15 → PRID_VALUE, others → 0.
  - No write-first bypass.
- epcOut is the registered EPC only. An mtc0 EPC followed by an eret is resolved by pipeline stalling, not inside this block.
- While EXL=1, Req stays 0 for both interrupts and exceptions (no nesting).
- A Req raised in a cycle affects state at that posedge only. The flushed M instruction presents excCodeIn=0 next cycle, and Req then drops because EXL=1.
- Reset asserted mid-handler clears EXL, so a pending interrupt can re-fire only after software sets IE again.
- Latency: one cycle for state updates; Req and cp0Out have zero latency.

Test Plan:
- Reset then read: reset=0 one cycle, release; read addr 12/13/14/15 → 0/0/0/0000_2022; Req=0.
- Masked interrupt: mtc0 SR=0000_0401 (IM0, IE), then hwInt=6'b000001, vpc=0000_3010, BD=0 → Req=1 that cycle. Next cycle: SR=0000_0403, Cause=0000_0400, EPC=0000_3010, Req=0.
- Delay-slot exception: excCodeIn=5'd10 (RI), delaySlotIn=1, vpc=0000_3024, SR=0 → Req=1. After edge: Cause=8000_0028, EPC=0000_3020. With vpc=0 → EPC=FFFF_FFFC.
- Interrupt beats exception and write: hwInt enabled, excCodeIn=4, en=1 with cp0Add=14 and cp0In=1234_5678, all same cycle → ExcCode=0, EPC=vpc (not 1234_5678).
- eret: EXL=1, exlClr=1 together with en=1, cp0Add=12, cp0In=0000_FC03 → SR=0000_FC01. With hwInt still high, Req=1 the following cycle.
- Write masking and read-only: en=1, addr 12, cp0In=FFFF_FFFF → SR reads 0000_FC03. en=1, addr 13, cp0In=FFFF_FFFF → Cause unchanged (only IP tracks hwInt).
